// File: rtl/window_pkg.sv
// Shared definitions for the window serializer.
//   WIDTH_DEF / DEPTH_DEF : default sample width and number of window slots
//   state_e               : serializer FSM states
//   idx_t                 : slot index type for the default depth
//   idx_width()           : index width for an arbitrary depth (never zero)
package window_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int DEPTH_DEF = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    // A depth of 1 still needs a one-bit index port.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(DEPTH_DEF);

    typedef logic [IDX_W_DEF-1:0] idx_t;

endpackage

// File: rtl/window_fill_counter.sv
// Saturating count of how many window slots hold pushed samples.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   en    : global enable; the count only moves while high
//   inc   : upstream window advanced this cycle
//   count : number of valid slots, 0..DEPTH
module window_fill_counter #(
    parameter int DEPTH = 5,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && inc && (count_q != CNT_W'(DEPTH))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/window_serializer.sv
// Snapshots a shift window and emits its filled slots one beat at a time,
// oldest first, over a valid/ready stream.
//
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   en        : global enable; when low nothing but reset changes state
//   push      : upstream window advanced this cycle (drives the fill count)
//   win       : flattened window, slot k at [k*WIDTH +: WIDTH], slot 0 newest
//   start     : request a burst (taken only while idle)
//   out_data  : emitted signed sample
//   out_idx   : slot index of the current beat
//   out_valid : beat valid
//   out_ready : downstream accepts the beat
//   out_last  : current beat is slot 0, the end of the burst
//   busy      : burst in progress
//
// Build option WINDOW_DEFAULT_EN: every burst is DEPTH beats long and slots
// that were never filled emit DEFAULT_VAL. Without it the burst length is
// the fill count captured at start.
module window_serializer
    import window_pkg::*;
#(
    parameter int                       WIDTH       = WIDTH_DEF,
    parameter int                       DEPTH       = DEPTH_DEF,
    parameter logic signed [WIDTH-1:0]  DEFAULT_VAL = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             push,
    input  logic [DEPTH*WIDTH-1:0]           win,
    input  logic                             start,
    output logic signed [WIDTH-1:0]          out_data,
    output logic [idx_width(DEPTH)-1:0]      out_idx,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             busy
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [WIDTH-1:0]  data_q, data_d;
    logic                     last_q, last_d;
    logic signed [WIDTH-1:0]  snap_q [DEPTH];
    logic signed [WIDTH-1:0]  snap_d [DEPTH];

    logic signed [WIDTH-1:0]  win_slot [DEPTH];
    logic [CNT_W-1:0]         fill_cnt;
    logic [CNT_W-1:0]         burst_len;
    logic [IDX_W-1:0]         first_idx;
    logic [IDX_W-1:0]         nxt_idx;
    logic                     accept;
    logic                     xfer;

    window_fill_counter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fill (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .inc   (push),
        .count (fill_cnt)
    );

    // Unfilled slots are replaced at capture time. Without the default
    // option they lie beyond the burst length and are never emitted.
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        assign win_slot[k] = (CNT_W'(k) < fill_cnt) ? win[k*WIDTH +: WIDTH] : DEFAULT_VAL;
    end

`ifdef WINDOW_DEFAULT_EN
    assign burst_len = CNT_W'(DEPTH);
`else
    assign burst_len = fill_cnt;
`endif

    assign first_idx = IDX_W'(burst_len - 1'b1);
    assign out_valid = (state_q == ST_EMIT);
    assign busy      = (state_q == ST_EMIT);
    assign accept    = en && start && (state_q == ST_IDLE) && (burst_len != '0);
    assign xfer      = en && out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        snap_d  = snap_q;
        nxt_idx = idx_q - 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    snap_d  = win_slot;
                    state_d = ST_EMIT;
                    idx_d   = first_idx;
                    data_d  = win_slot[first_idx];
                    last_d  = (first_idx == '0);
                end
            end
            ST_EMIT: begin
                if (xfer) begin
                    if (idx_q == '0) begin
                        state_d = ST_IDLE;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = nxt_idx;
                        data_d = snap_q[nxt_idx];
                        last_d = (nxt_idx == '0);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Snapshot storage is pure datapath; it is only read while emitting.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign out_data = data_q;
    assign out_idx  = idx_q;
    assign out_last = last_q;

endmodule

// File: tb/tb_window_serializer.sv
module tb_window_serializer;

    localparam int W = 64;
    localparam int D = 5;

    logic                   clk = 1'b0;
    logic                   rst, en, push, start, out_ready;
    logic [D*W-1:0]         win_flat;
    logic signed [W-1:0]    out_data;
    logic [2:0]             out_idx;
    logic                   out_valid, out_last, busy;

    window_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .push      (push),
        .win       (win_flat),
        .start     (start),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: upstream shift window, fill count and the list of beats
    // still owed for the current burst.
    typedef struct {
        logic signed [W-1:0] d;
        int                  idx;
    } beat_t;

    logic signed [W-1:0] win_m [D];
    int                  fill_m;
    beat_t               q_m [$];
    logic [W-1:0]        seen [$];
    logic [W-1:0]        exp_seen [$];
    int                  n_vec = 0;
    int                  n_err = 0;

    always_comb begin
        win_flat = '0;
        for (int k = 0; k < D; k++) win_flat[k*W +: W] = win_m[k];
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic p,
                              input logic signed [W-1:0] pv, input logic s, input logic rd);
        bit busy_pre;
        int n;
        if (r) begin
            q_m.delete();
            fill_m = 0;
            return;
        end
        if (!e) return;
        busy_pre = (q_m.size() != 0);
        if (busy_pre && rd) void'(q_m.pop_front());
        if (!busy_pre && s) begin
`ifdef WINDOW_DEFAULT_EN
            n = D;
`else
            n = fill_m;
`endif
            for (int k = n - 1; k >= 0; k--) begin
                beat_t b;
                b.d   = (k < fill_m) ? win_m[k] : '0;
                b.idx = k;
                q_m.push_back(b);
            end
        end
        if (p) begin
            for (int k = D - 1; k > 0; k--) win_m[k] = win_m[k-1];
            win_m[0] = pv;
            if (fill_m < D) fill_m++;
        end
    endtask

    task automatic compare();
        bit act = (q_m.size() != 0);
        check_val("out_valid", out_valid, act);
        check_val("busy", busy, act);
        if (act) begin
            check_val("out_data", out_data, q_m[0].d);
            check_val("out_idx", out_idx, q_m[0].idx);
            check_val("out_last", out_last, q_m[0].idx == 0);
        end else begin
            check_val("out_last_idle", out_last, 0);
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic p,
                       input logic signed [W-1:0] pv, input logic s, input logic rd);
        rst = r; en = e; push = p; start = s; out_ready = rd;
        if (!r && e && rd && out_valid) seen.push_back(out_data);
        @(posedge clk);
        #1;
        model_step(r, e, p, pv, s, rd);
        compare();
    endtask

    task automatic do_push(input logic signed [W-1:0] v);
        cyc(0, 1, 1, v, 0, 0);
    endtask

    task automatic run_ready(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 1);
    endtask

    task automatic check_seen(input string tag);
        check_val({tag, "_count"}, seen.size(), exp_seen.size());
        for (int i = 0; i < exp_seen.size() && i < seen.size(); i++)
            check_val(tag, seen[i], exp_seen[i]);
        seen.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_idx"}, out_idx, 0);
        check_val({tag, "_data"}, out_data, 0);
        check_val({tag, "_last"}, out_last, 0);
    endtask

    initial begin
        for (int k = 0; k < D; k++) win_m[k] = '0;
        fill_m = 0;
        rst = 1; en = 0; push = 0; start = 0; out_ready = 0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 64'd3, 1, 1);
        check_reset_outputs("reset");

        // Full window, continuous ready.
        for (int v = 1; v <= 5; v++) do_push(v);
        seen.delete();
        cyc(0, 1, 0, 0, 1, 1);
        run_ready(6);
        exp_seen = {64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
        check_seen("full_burst");

        // Partial window.
        cyc(1, 1, 0, 0, 0, 0);
        do_push(7);
        do_push(8);
        cyc(0, 1, 0, 0, 1, 1);
        run_ready(6);
`ifdef WINDOW_DEFAULT_EN
        exp_seen = {64'd0, 64'd0, 64'd0, 64'd7, 64'd8};
`else
        exp_seen = {64'd7, 64'd8};
`endif
        check_seen("partial_burst");

        // Backpressure on beat 2.
        for (int v = 1; v <= 5; v++) do_push(v);
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
        run_ready(6);
        exp_seen = {64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
        check_seen("backpressure");

        // Start and push in the same cycle.
        cyc(0, 1, 1, 64'd9, 1, 1);
        run_ready(6);
        exp_seen = {64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
        check_seen("start_push_same");
        cyc(0, 1, 0, 0, 1, 1);
        run_ready(6);
        exp_seen = {64'd2, 64'd3, 64'd4, 64'd5, 64'd9};
        check_seen("after_push");

        // Reset on the third beat, then start with an empty window.
        cyc(0, 1, 0, 0, 1, 1);
        run_ready(2);
        cyc(1, 1, 0, 0, 0, 1);
        check_reset_outputs("mid_reset");
        seen.delete();
        cyc(0, 1, 0, 0, 1, 1);
        run_ready(6);
`ifdef WINDOW_DEFAULT_EN
        exp_seen = {64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
`else
        exp_seen = {};
`endif
        check_seen("empty_start");

        // Enable dropped mid-burst with ready held high.
        for (int v = 11; v <= 15; v++) do_push(v);
        cyc(0, 1, 0, 0, 1, 1);
        run_ready(2);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 64'd99, 1, 1);
        run_ready(6);
        exp_seen = {64'd11, 64'd12, 64'd13, 64'd14, 64'd15};
        check_seen("enable_freeze");

        // Random traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            logic r, e, p, s, rd;
            logic signed [W-1:0] v;
            r  = ($urandom_range(0, 99) < 2);
            e  = ($urandom_range(0, 99) < 90);
            p  = ($urandom_range(0, 99) < 35);
            s  = ($urandom_range(0, 99) < 25);
            rd = ($urandom_range(0, 99) < 65);
            v  = {$urandom(), $urandom()};
            cyc(r, e, p, v, s, rd);
        end
        run_ready(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/window_serializer.md
WINDOW_SERIALIZER -- requirements
Module: window_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 64, sample width in bits (signed).
REQ-002 SHALL have parameter DEPTH, default 5, number of window slots.
REQ-003 SHALL have parameter DEFAULT_VAL, default 0, substitute sample for unfilled slots (used only under WINDOW_DEFAULT_EN).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  global enable; when low, no register changes except reset.
REQ-007 SHALL have port push  input  1  upstream shift window advanced this cycle.
REQ-008 SHALL have port win  input  DEPTH*WIDTH  flattened window; slot k at [k*WIDTH +: WIDTH], slot 0 newest.
REQ-009 SHALL have port start  input  1  request to snapshot and emit the window.
REQ-010 SHALL have port out_data  output  WIDTH  signed emitted sample.
REQ-011 SHALL have port out_idx  output  clog2(DEPTH)  slot index (offset) of the current beat.
REQ-012 SHALL have port out_valid  output  1  beat valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-014 SHALL have port out_last  output  1  current beat is the final one of the burst.
REQ-015 SHALL have port busy  output  1  burst in progress.

Function
REQ-016 SHALL keep fill count: +1 on en&&push, saturating at DEPTH.
REQ-017 SHALL use states IDLE and EMIT only.
REQ-018 SHALL accept start only when en&&start in IDLE; start in EMIT SHALL be ignored.
REQ-019 SHALL on acceptance snapshot win and fill; later push or win changes SHALL not affect the burst.
REQ-020 SHALL assert out_valid and busy in the cycle after acceptance (latency 1).
REQ-021 SHALL emit oldest-first: out_idx from N-1 down to 0, out_data = snapshot slot out_idx.
REQ-022 SHALL complete a transfer only on en&&out_valid&&out_ready; out_data, out_idx, out_last SHALL stay stable otherwise.
REQ-023 SHALL sustain one beat per cycle while out_ready and en are held high.
REQ-024 SHALL assert out_last only on the out_idx==0 beat; after its transfer SHALL return to IDLE, out_valid=0, busy=0.
REQ-025 SHALL, when N==0 at acceptance, stay in IDLE and emit nothing.
REQ-026 SHALL, on push and transfer in the same cycle, apply both independently.

Reset
REQ-027 SHALL on rst, including mid-burst, force IDLE, fill=0, out_valid=0, out_last=0, busy=0, out_idx=0, out_data=0.
REQ-028 SHALL give rst priority over en, start and push.

Configuration
REQ-029 SHALL, without WINDOW_DEFAULT_EN, set burst length N = captured fill.
REQ-030 SHALL, with WINDOW_DEFAULT_EN, set N = DEPTH always; slots with index >= fill SHALL emit DEFAULT_VAL.

Structure
REQ-031 SHALL place WIDTH/DEPTH defaults, state enum and index typedef in package window_pkg.
REQ-032 SHALL implement the saturating fill counter as sub-module window_fill_counter.

Verification
REQ-033 SHALL cover: push 1,2,3,4,5 (slot0=5), start, ready=1 -> beats 1,2,3,4,5 on consecutive cycles, idx 4..0, last with 5.
REQ-034 SHALL cover: push 7,8 only, start -> beats 7,8, last with 8; with WINDOW_DEFAULT_EN -> 0,0,0,7,8.
REQ-035 SHALL cover: burst of 1..5 with ready low 3 cycles on beat 2 -> value 2 held stable, no skipped or duplicated beats.
REQ-036 SHALL cover: start and push 9 in the same cycle -> burst emits the pre-push window; next start includes 9.
REQ-037 SHALL cover: rst asserted on 3rd beat -> next cycle out_valid=0, busy=0; start without pushes emits nothing.
REQ-038 SHALL cover: en low mid-burst with ready=1 -> no transfer, outputs frozen; resumes on en high.
